multicycle_controller: RTL and testbench

- Multicycle MIPS control unit: Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks.
- Drives the shared-memory multicycle datapath: single ALU, IR/PC enables, memory address mux.
- Adds `bne` and `addi` support, a parametrised memory wait-state counter, an illegal-opcode flag and a visible state register.

---
 rtl/multicycle_controller.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore sequencer for fetch/decode/execute/
// memory/writeback, with bne/addi, memory wait states and an illegal-op flag.
module multicycle_controller #(
  parameter int MEM_LAT  = 0,
  parameter int ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                iord,
  output logic                memwrite,
  output logic                irwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic                pcen,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                illegal,
  output logic [3:0]          state
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               final_cyc;
  logic               pcwrite, irwrite_s, regwrite_s, memwrite_s;
  aluop_t             aluop;
  logic [2:0]         aluctl_code;

  // Wait states end when the counter reaches the configured latency.
  assign final_cyc = (cnt_q == CNT_W'(MEM_LAT));

  // State register and wait counter; the counter restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      if (state_d != state_q) cnt_q <= '0;
      else                    cnt_q <= cnt_q + 1'b1;
    end
  end

  // Next-state and Moore control outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d    = FETCH;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    aluop      = ALUOP_ADD;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        if (final_cyc) begin
          irwrite_s = 1'b1;
          pcwrite   = 1'b1;
          state_d   = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE:     state_d = RTYPEEX;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BEQEX;
          OP_BNE:       state_d = BNEEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = final_cyc ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
        state_d    = final_cyc ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQEX, BNEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB:  regwrite_s = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // ALU decoder: fixed add/sub, or funct-driven for R-type execute.
  always_comb begin
    aluctl_code = 3'b010;
    case (aluop)
      ALUOP_SUB: aluctl_code = 3'b110;
      ALUOP_FUNCT: begin
        case (funct)
          6'b100010: aluctl_code = 3'b110;
          6'b100100: aluctl_code = 3'b000;
          6'b100101: aluctl_code = 3'b001;
          6'b101010: aluctl_code = 3'b111;
          default:   aluctl_code = 3'b010;
        endcase
      end
      default: aluctl_code = 3'b010;
    endcase
  end

  assign alucontrol = ALUCTL_W'(aluctl_code);

  // Architectural write strobes are suppressed while reset is held.
  assign pcen     = (pcwrite | ((state_q == BEQEX) & zero) | ((state_q == BNEEX) & ~zero)) & ~reset;
  assign irwrite  = irwrite_s  & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: two controllers (MEM_LAT=0 and MEM_LAT=2) compared
// against an instruction-level model of the expected per-cycle control trace.
module tb_multicycle_controller;

  typedef struct packed {
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] aluctl;
    logic       illegal;
    logic [3:0] state;
  } obs_t;

  logic clk, reset, zero, sel;
  logic [5:0] op, funct;

  logic       iord0, mw0, irw0, rd0, m2r0, rw0, asa0, pcen0, ill0;
  logic [1:0] asb0, pcs0;
  logic [2:0] alu0;
  logic [3:0] st0;
  logic       iord2, mw2, irw2, rd2, m2r2, rw2, asa2, pcen2, ill2;
  logic [1:0] asb2, pcs2;
  logic [2:0] alu2;
  logic [3:0] st2;

  int errors = 0;
  int checks = 0;
  obs_t exp_q[$];

  multicycle_controller #(.MEM_LAT(0), .ALUCTL_W(3)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord0), .memwrite(mw0), .irwrite(irw0), .regdst(rd0), .memtoreg(m2r0),
    .regwrite(rw0), .alusrca(asa0), .alusrcb(asb0), .pcsrc(pcs0), .pcen(pcen0),
    .alucontrol(alu0), .illegal(ill0), .state(st0));

  multicycle_controller #(.MEM_LAT(2), .ALUCTL_W(3)) dut2 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord2), .memwrite(mw2), .irwrite(irw2), .regdst(rd2), .memtoreg(m2r2),
    .regwrite(rw2), .alusrca(asa2), .alusrcb(asb2), .pcsrc(pcs2), .pcen(pcen2),
    .alucontrol(alu2), .illegal(ill2), .state(st2));

  obs_t obs0, obs2, obs;
  assign obs0 = '{iord0, mw0, irw0, rd0, m2r0, rw0, asa0, asb0, pcs0, pcen0, alu0, ill0, st0};
  assign obs2 = '{iord2, mw2, irw2, rd2, m2r2, rw2, asa2, asb2, pcs2, pcen2, alu2, ill2, st2};
  assign obs  = sel ? obs2 : obs0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic is_legal(input logic [5:0] o);
    return o inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02};
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs of one cycle spent in step 'st' of an instruction.
  function automatic obs_t cyc(input int st, input logic fin, input logic [5:0] o,
                               input logic [5:0] f, input logic z);
    obs_t e = '0;
    e.state  = 4'(st);
    e.aluctl = 3'b010;
    case (st)
      0:  begin e.alusrcb = 2'b01; e.irwrite = fin; e.pcen = fin; end
      1:  begin e.alusrcb = 2'b11; e.illegal = ~is_legal(o); end
      2, 9: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      3:  e.iord = 1'b1;
      4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
      6:  begin e.alusrca = 1'b1; e.aluctl = rtype_alu(f); end
      7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      8, 12: begin
        e.alusrca = 1'b1; e.aluctl = 3'b110; e.pcsrc = 2'b01;
        e.pcen = (st == 8) ? z : ~z;
      end
      10: e.regwrite = 1'b1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // Append the whole expected cycle trace of one instruction.
  task automatic plan(input logic [5:0] o, input logic [5:0] f, input logic z, input int lat);
    for (int i = 0; i <= lat; i++) exp_q.push_back(cyc(0, i == lat, o, f, z));
    exp_q.push_back(cyc(1, 1'b0, o, f, z));
    case (o)
      6'h23: begin
        exp_q.push_back(cyc(2, 1'b0, o, f, z));
        for (int i = 0; i <= lat; i++) exp_q.push_back(cyc(3, i == lat, o, f, z));
        exp_q.push_back(cyc(4, 1'b0, o, f, z));
      end
      6'h2b: begin
        exp_q.push_back(cyc(2, 1'b0, o, f, z));
        for (int i = 0; i <= lat; i++) exp_q.push_back(cyc(5, i == lat, o, f, z));
      end
      6'h00: begin exp_q.push_back(cyc(6, 1'b0, o, f, z)); exp_q.push_back(cyc(7, 1'b0, o, f, z)); end
      6'h04: exp_q.push_back(cyc(8, 1'b0, o, f, z));
      6'h05: exp_q.push_back(cyc(12, 1'b0, o, f, z));
      6'h08: begin exp_q.push_back(cyc(9, 1'b0, o, f, z)); exp_q.push_back(cyc(10, 1'b0, o, f, z)); end
      6'h02: exp_q.push_back(cyc(11, 1'b0, o, f, z));
      default: ;
    endcase
  endtask

  task automatic advance();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    e = '0;
    e.alusrcb = 2'b01;
    e.aluctl  = 3'b010;
    sel = 1'b0;
    reset = 1'b1;
    op = 6'h00; funct = 6'h20; zero = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < 2; d++) begin
        sel = d[0];
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL reset_hold dut%0d: got=%h required=%h", d * 2, obs, e);
        end
      end
      advance();
    end
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_lw();
    obs_t e;
    op = 6'h23; funct = 6'h00; zero = 1'b0;
    plan(op, funct, zero, 0);
    for (int c = 0; exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL lw cyc%0d: got=%h required=%h", c, obs, e);
      end
      advance();
    end
  endtask

  task automatic test_rtype();
    obs_t e;
    logic [5:0] fl[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    for (int n = 0; n < 6; n++) begin
      op = 6'h00; funct = (n < 5) ? fl[n] : 6'h3f; zero = n[0];
      plan(op, funct, zero, 0);
      for (int c = 0; exp_q.size() > 0; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL rtype funct=%h cyc%0d: got=%h required=%h", funct, c, obs, e);
        end
        advance();
      end
    end
  endtask

  task automatic test_branches();
    obs_t e;
    logic [5:0] bo[4] = '{6'h04, 6'h04, 6'h05, 6'h05};
    for (int n = 0; n < 4; n++) begin
      op = bo[n]; funct = 6'h00; zero = ~n[0];
      plan(op, funct, zero, 0);
      for (int c = 0; exp_q.size() > 0; c++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL branch op=%h zero=%0b cyc%0d: got=%h required=%h", op, zero, c, obs, e);
        end
        advance();
      end
    end
  endtask

  task automatic test_illegal();
    obs_t e;
    op = 6'h3f; funct = 6'h00; zero = 1'b0;
    plan(op, funct, zero, 0);
    plan(6'h3f, funct, zero, 0);
    exp_q.pop_back();
    for (int c = 0; exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL illegal cyc%0d: got=%h required=%h", c, obs, e);
      end
      advance();
    end
  endtask

  task automatic test_sw_wait();
    obs_t e;
    sel = 1'b1;
    do_reset();
    op = 6'h2b; funct = 6'h00; zero = 1'b0;
    plan(op, funct, zero, 2);
    plan(6'h08, funct, zero, 2);
    for (int c = 0; exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      if (c == 9) op = 6'h08;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL sw_wait cyc%0d: got=%h required=%h", c, obs, e);
      end
      advance();
    end
  endtask

  task automatic test_reset_abort();
    obs_t e;
    sel = 1'b1;
    do_reset();
    op = 6'h2b; funct = 6'h00; zero = 1'b0;
    plan(op, funct, zero, 2);
    for (int c = 0; c < 6; c++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL abort_pre cyc%0d: got=%h required=%h", c, obs, e);
      end
      if (c < 5) advance();
    end
    exp_q.delete();
    reset = 1'b1;
    #1;
    checks++;
    if ({obs.memwrite, obs.regwrite, obs.iord, obs.state} !== 7'b0) begin
      errors++;
      $display("FAIL abort_reset: got mw=%0b rw=%0b iord=%0b state=%0d required 0,0,0,0",
               obs.memwrite, obs.regwrite, obs.iord, obs.state);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back(input logic d);
    obs_t e;
    logic [5:0] ol[7] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02};
    logic [5:0] fl[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    logic [5:0] ops[$];
    logic [5:0] fns[$];
    logic       zs[$];
    int         bounds[$];
    int         idx;
    sel = d;
    do_reset();
    for (int n = 0; n < 25; n++) begin
      idx = $urandom_range(0, 7);
      ops.push_back((idx < 7) ? ol[idx] : 6'($urandom_range(0, 63)));
      idx = $urandom_range(0, 5);
      fns.push_back((idx < 5) ? fl[idx] : 6'($urandom_range(0, 63)));
      zs.push_back(1'($urandom_range(0, 1)));
      plan(ops[n], fns[n], zs[n], d ? 2 : 0);
      bounds.push_back(exp_q.size());
    end
    idx = 0;
    op = ops[0]; funct = fns[0]; zero = zs[0];
    for (int c = 0; exp_q.size() > 0; c++) begin
      if (c == bounds[idx]) begin
        idx++;
        op = ops[idx]; funct = fns[idx]; zero = zs[idx];
      end
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL random dut%0d op=%h cyc%0d: got=%h required=%h", d ? 2 : 0, op, c, obs, e);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_branches();
    test_illegal();
    test_sw_wait();
    test_reset_abort();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
